// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round-key index width,
// round constants and the key-expansion FSM state encoding.
package aes_pkg;

  localparam int NR       = 10;
  localparam int RK_IDX_W = 4;
  localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Rcon[i] for rounds 1..NR; doublings in GF(2^8), so 0x80 wraps to 0x1b.
  function automatic logic [7:0] rcon(input logic [RK_IDX_W-1:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational byte substitution.
module sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 occupies the most significant byte, so entry x sits at (255-x)*8 = {~x,3'b0}.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_T[{~x, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key expansion: one round key per cycle, idx 0..10.
// Optional KEY_EXPANSION_STORE_EN adds an 11-entry round-key store with rd_idx/rd_key read port.
module key_expansion
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        key_in,
  output logic                busy,
  output logic                rk_valid,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic [127:0]        rk_out,
  output logic                done
`ifdef KEY_EXPANSION_STORE_EN
  ,
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [127:0]        rd_key
`endif
);

  state_t state_q, state_d;
  logic [127:0]        rk_p0;
  logic [RK_IDX_W-1:0] idx_p0;
  logic [RK_IDX_W-1:0] idx_inc;
  logic [31:0]         w0, w1, w2, w3, rot, sub, t;
  logic [31:0]         n0, n1, n2, n3;

  // ---- round function: previous round key -> next round key ----
  assign {w0, w1, w2, w3} = rk_p0;
  assign idx_inc = idx_p0 + 4'd1;
  assign rot     = {w3[23:0], w3[31:24]};

  sbox u_sbox0 (.x(rot[31:24]), .y(sub[31:24]));
  sbox u_sbox1 (.x(rot[23:16]), .y(sub[23:16]));
  sbox u_sbox2 (.x(rot[15:8]),  .y(sub[15:8]));
  sbox u_sbox3 (.x(rot[7:0]),   .y(sub[7:0]));

  assign t  = sub ^ {rcon(idx_inc), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (idx_p0 == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == EXPAND);
    rk_valid = busy;
    done     = busy && (idx_p0 == LAST_IDX);
  end

  // ---- round-key register: load on accept, advance until idx 10, then hold ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_p0  <= '0;
      idx_p0 <= '0;
    end else if (state_q == IDLE && start) begin
      rk_p0  <= key_in;
      idx_p0 <= '0;
    end else if (state_q == EXPAND && idx_p0 != LAST_IDX) begin
      rk_p0  <= {n0, n1, n2, n3};
      idx_p0 <= idx_inc;
    end
  end

  assign rk_out = rk_p0;
  assign rk_idx = idx_p0;

`ifdef KEY_EXPANSION_STORE_EN
  logic [127:0] store [0:NR];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (rk_valid) begin
      store[idx_p0] <= rk_p0;
    end
  end

  assign rd_key = (rd_idx <= LAST_IDX) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion with an independent GF(2^8) key-schedule model
// feeding a cycle-stamped scoreboard. Store checks run when KEY_EXPANSION_STORE_EN is defined.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef KEY_EXPANSION_STORE_EN
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;
`endif

  key_expansion dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_out(rk_out), .done(done)
`ifdef KEY_EXPANSION_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, nvalid = 0, ndone = 0;

  typedef struct {
    int           cyc;
    int           idx;
    logic [127:0] key;
    int           done;
  } exp_t;
  exp_t exp_q[$];
  logic [127:0] obs [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check128(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // ---- reference model: S-box from GF(2^8) inverse plus affine map ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    if (b != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk_m(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, r, s;
    {w0, w1, w2, w3} = k;
    r = {w3[23:0], w3[31:24]};
    s = {sbox_m(r[31:24]), sbox_m(r[23:16]), sbox_m(r[15:8]), sbox_m(r[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ s;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic push_run(input logic [127:0] key, input int n, input int base);
    logic [127:0] k = key;
    logic [7:0]   rc = 8'h01;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        k  = next_rk_m(k, rc);
        rc = gmul(rc, 8'h02);
      end
      e.cyc = base + i; e.idx = i; e.key = k; e.done = (i == 10) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; entries expect idx i observed i cycles after the accepting edge.
  task automatic begin_run(input logic [127:0] key, input int n);
    key_in = key;
    start  = 1'b1;
    push_run(key, n, cyc + 1);
    tick();
    start  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      nvalid++;
      if (done === 1'b1) ndone++;
      check_int("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_int("rk_cycle", cyc, e.cyc);
        check_int("rk_idx", int'(rk_idx), e.idx);
        check128("rk_out", rk_out, e.key);
        check_int("done", int'(done), e.done);
      end
      if (rk_idx <= 4'd10) obs[rk_idx] = rk_out;
    end else if (done !== 1'b0) begin
      check_int("done_without_valid", int'(done), 0);
    end
  end

  initial begin
    int t0, nv0;
    logic [127:0] rkey;

    // ---- reset state ----
    tick(); tick();
    rst = 1'b0;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_valid", int'(rk_valid), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_idx", int'(rk_idx), 0);
    check128("rst_rk_out", rk_out, 128'h0);
`ifdef KEY_EXPANSION_STORE_EN
    rd_idx = 4'd1; #1;
    check128("rst_rd_key", rd_key, 128'h0);
`endif

    // ---- FIPS key, key_in changed mid-run, start pulsed at T+5 and T+11 ----
    begin_run(FIPS_KEY, 11);
    t0 = cyc;
    check_int("busy_in_run", int'(busy), 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) key_in = {$urandom, $urandom, $urandom, $urandom};
      start = (k == 4 || k == 10) ? 1'b1 : 1'b0;
    end
    tick();
    start = 1'b0;
    check_int("busy_after_run", int'(busy), 0);
    check_int("run1_length", cyc - t0, 11);
    check128("fips_idx0", obs[0], FIPS_KEY);
    check128("fips_idx1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check128("fips_idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // ---- back-to-back all-zero key at the first idle edge ----
    begin_run(128'h0, 11);
    repeat (12) tick();
    check_int("sb_drained_1", exp_q.size(), 0);
    check_int("valid_count_2runs", nvalid, 22);
    check_int("done_count_2runs", ndone, 2);
    check128("zero_idx1", obs[1], 128'h62636363626363636263636362636363);
    check128("zero_idx10", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // ---- reset mid-run at T+6 ----
    begin_run(FIPS_KEY, 6);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_valid", int'(rk_valid), 0);
    check_int("abort_idx", int'(rk_idx), 0);
    check128("abort_rk_out", rk_out, 128'h0);
    repeat (12) tick();
    check_int("sb_drained_abort", exp_q.size(), 0);
    check_int("done_count_abort", ndone, 2);

    rkey = {$urandom, $urandom, $urandom, $urandom};
    begin_run(rkey, 11);
    repeat (12) tick();
    check_int("sb_drained_fresh", exp_q.size(), 0);
    check_int("done_count_fresh", ndone, 3);

    // ---- simultaneous rst and start ----
    nv0 = nvalid;
    rst = 1'b1; start = 1'b1; key_in = FIPS_KEY;
    tick();
    rst = 1'b0; start = 1'b0;
    check_int("rst_start_busy", int'(busy), 0);
    repeat (4) tick();
    check_int("rst_start_busy_later", int'(busy), 0);
    check_int("rst_start_no_valid", nvalid, nv0);

`ifdef KEY_EXPANSION_STORE_EN
    // ---- round-key store readback ----
    begin_run(FIPS_KEY, 11);
    repeat (12) tick();
    rd_idx = 4'd1; #1;
    check128("store_rd1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd10; #1;
    check128("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd15; #1;
    check128("store_rd15", rd_key, 128'h0);
    rd_idx = 4'd0; #1;
    check128("store_rd0", rd_key, FIPS_KEY);
`endif

    check_int("sb_final_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request expansion of key_in; sampled only while busy=0.
REQ-005 SHALL have port key_in, input, 128 bits: cipher key; [127:120] is byte 0, and w0=[127:96].
REQ-006 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-007 SHALL have port rk_valid, output, 1 bit: rk_out/rk_idx valid this cycle.
REQ-008 SHALL have port rk_idx, output, 4 bits: round-key index 0..10.
REQ-009 SHALL have port rk_out, output, 128 bits: round key, same byte order as key_in.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse coincident with rk_idx=10.

Function
REQ-011 SHALL implement an FSM with states IDLE and EXPAND.
- IDLE->EXPAND on start=1.
- EXPAND->IDLE after the cycle presenting rk_idx=10.
REQ-012 SHALL behave as follows when start=1 in IDLE at edge T:
- T+1: rk_valid=1, rk_idx=0, rk_out=key_in as captured at T, busy=1.
- T+1+i: rk_idx=i for i=1..10.
- T+11: done=1.
- T+12: busy=0, rk_valid=0.
REQ-013 SHALL latch key_in at the accepting edge; later key_in changes have no effect on the run.
REQ-014 SHALL compute round key i from round key i-1 (words w0..w3) in one cycle:
- t = SubWord(RotWord(w3)) XOR {Rcon[i],24'h0}.
- w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-015 SHALL define RotWord as a rotate left by one byte; SubWord as the AES S-box applied to each of 4 bytes.
REQ-016 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; all arithmetic is bitwise XOR, no carries.
REQ-017 SHALL ignore start while busy=1, including the done cycle; back-to-back runs start no earlier than the first busy=0 cycle.
REQ-018 SHALL hold rk_out/rk_idx stable when rk_valid=0 (last values or zero after reset); consumers SHALL NOT rely on them.
REQ-019 SHALL have rk_idx never exceed 10 and never wrap within a run.

Reset
REQ-020 SHALL, when rst=1 at an edge, set the state to IDLE and drive busy, rk_valid and done to 0, rk_idx to 0 and rk_out to 0 from the next cycle.
REQ-021 SHALL abort a run on rst asserted mid-run; no further rk_valid or done for that run.
REQ-022 SHALL give rst priority over a simultaneous start; that start is dropped.

Configuration
REQ-023 SHALL support macro KEY_EXPANSION_STORE_EN.
- Defined: adds a register file of 11x128-bit round keys, written as each rk_valid occurs.
- Defined: adds ports rd_idx (input, 4 bits) and rd_key (output, 128 bits).
- Defined: rd_key = stored key[rd_idx], combinational; 0 for rd_idx>10 or entries not yet written since reset.
- Defined: reset clears all entries to 0.
- Not defined: no storage and no rd_* ports; streaming outputs identical.

Structure
REQ-024 SHALL place the following in shared package aes_pkg: NR=10, RK_IDX_W=4, the Rcon table/function, and the FSM state enum.
REQ-025 SHALL instantiate the existing sbox module four times for SubWord; no other sub-module.

Verification
REQ-026 SHALL cover FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c + start:
- idx0 = key.
- idx1 = a0fafe1788542cb123a339392a6c7605.
- idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1 at T+11.
REQ-027 SHALL cover an all-zero key:
- idx1 = 62636363626363636263636362636363.
- idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 SHALL cover start pulsed at T+5 and at T+11 of a run: both ignored, exactly 11 rk_valid cycles; start at T+12 begins a new run with idx0 at T+13.
REQ-029 SHALL cover rst asserted at T+6: outputs 0 at T+7, no done; then a fresh start yields correct idx1..10.
REQ-030 SHALL cover simultaneous rst and start: busy stays 0 and no rk_valid follows.
REQ-031 SHALL cover, with KEY_EXPANSION_STORE_EN defined after the FIPS run:
- rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
- rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- rd_idx=15 -> 0.
